// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers, default geometry and the status-flag bundle for the parametrised sync FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Pointer width for a power-of-two depth; the occupancy counter needs one more bit.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH register array: one write port, one registered read port (1-cycle read latency).
// No backpressure; the read register resets to zero while the array itself is never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_dat_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Holds the last word read when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: 1-cycle registered read, full+rd accepts wr, empty+wr rejects rd.
// Rejected requests raise registered overflow/underflow pulses; SYNC_FIFO_PEAK_EN adds a peak watermark.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd,
  output logic [WIDTH-1:0]           data_out,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [cnt_w(DEPTH)-1:0]    fifo_cnt,
`ifdef SYNC_FIFO_PEAK_EN
  input  logic                       peak_clr,
  output logic [cnt_w(DEPTH)-1:0]    peak_cnt,
`endif
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, overflow_q, underflow_q;
  logic              rd_acc, wr_acc;
  fifo_flags_t       flags;

  // Flags decode the registered count only, so they never glitch on wr/rd.
  always_comb begin
    flags.empty        = (cnt_q == '0);
    flags.full         = (cnt_q == CNT_W'(DEPTH));
    flags.almost_empty = (cnt_q <= CNT_W'(AE_THRESH));
    flags.almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
  end

  assign rd_acc = rd && !flags.empty;
  assign wr_acc = wr && (!flags.full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= wr && !wr_acc;
      underflow_q <= rd && !rd_acc;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr_q),
    .wr_dat_i (data_in),
    .rd_en_i  (rd_acc),
    .rd_addr_i(rd_ptr_q),
    .rd_dat_o (data_out)
  );

`ifdef SYNC_FIFO_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = cnt_q;
    end else if (cnt_q > peak_q) begin
      peak_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_cnt = peak_q;
`endif

  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign fifo_cnt     = cnt_q;
  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_empty = flags.almost_empty;
  assign almost_full  = flags.almost_full;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed and random traffic checked against a queue-based occupancy model.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr, rd;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid, empty, full, almost_empty, almost_full;
  logic [3:0]       fifo_cnt;
  logic             overflow, underflow;
`ifdef SYNC_FIFO_PEAK_EN
  logic             peak_clr;
  logic [3:0]       peak_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain queue plus the expected registered outputs.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_rv, exp_ovf, exp_unf;
  int               exp_peak;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .data_in     (data_in),
    .rd          (rd),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .fifo_cnt    (fifo_cnt),
`ifdef SYNC_FIFO_PEAK_EN
    .peak_clr    (peak_clr),
    .peak_cnt    (peak_cnt),
`endif
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_rv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    exp_peak = 0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".cnt"},   32'(fifo_cnt),     32'(n));
    chk({tag, ".dout"},  32'(data_out),     32'(exp_dout));
    chk({tag, ".rv"},    32'(rd_valid),     32'(exp_rv));
    chk({tag, ".ovf"},   32'(overflow),     32'(exp_ovf));
    chk({tag, ".unf"},   32'(underflow),    32'(exp_unf));
    chk({tag, ".empty"}, 32'(empty),        32'(n == 0));
    chk({tag, ".full"},  32'(full),         32'(n == DEPTH));
    chk({tag, ".ae"},    32'(almost_empty), 32'(n <= AE));
    chk({tag, ".af"},    32'(almost_full),  32'(n >= AF));
`ifdef SYNC_FIFO_PEAK_EN
    chk({tag, ".peak"},  32'(peak_cnt),     32'(exp_peak));
`endif
  endtask

  // One clock: drive request, advance the model by the FIFO rules, compare after the edge.
  task automatic step(input string tag, input logic w, input logic [WIDTH-1:0] d,
                      input logic r, input logic clr = 1'b0);
    bit racc, wacc;
    int occ;
    wr      = w;
    data_in = d;
    rd      = r;
`ifdef SYNC_FIFO_PEAK_EN
    peak_clr = clr;
`endif
    occ  = q.size();
    racc = r && (occ > 0);
    wacc = w && ((occ < DEPTH) || racc);
    if (clr) exp_peak = occ;
    else if (occ > exp_peak) exp_peak = occ;
    if (racc) exp_dout = q.pop_front();
    if (wacc) q.push_back(d);
    exp_rv  = racc;
    exp_ovf = w && !wacc;
    exp_unf = r && !racc;
    @(posedge clk);
    #1;
    check_all(tag);
    wr = 1'b0;
    rd = 1'b0;
`ifdef SYNC_FIFO_PEAK_EN
    peak_clr = 1'b0;
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] last_out;
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    data_in = '0;
`ifdef SYNC_FIFO_PEAK_EN
    peak_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Fill 0x01..0x08, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
    step("ovf", 1'b1, 8'hEE, 1'b0);

    // Drain in order, then one rejected read; data_out holds 0x08.
    for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
    step("unf", 1'b0, '0, 1'b1);
    chk("unf.hold", 32'(data_out), 32'h08);

    // Full with simultaneous read and write.
    for (int i = 1; i <= DEPTH; i++) step("fill2", 1'b1, 8'(i), 1'b0);
    step("full_rw", 1'b1, 8'hAA, 1'b1);
    chk("full_rw.dout", 32'(data_out), 32'h01);
    last_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      step("drain2", 1'b0, '0, 1'b1);
      last_out = data_out;
    end
    chk("drain2.last", 32'(last_out), 32'hAA);

    // Empty with simultaneous read and write: no fall-through.
    step("empty_rw", 1'b1, 8'h55, 1'b1);
    step("empty_rd", 1'b0, '0, 1'b1);
    chk("empty_rd.dout", 32'(data_out), 32'h55);

    // Interleaved traffic around occupancy 3 to exercise pointer wrap.
    for (int i = 0; i < 3; i++) step("pre", 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step("wrap", 1'(i % 2 == 0 || $urandom_range(0, 1)),
                                       8'($urandom), 1'(i % 2 == 1 || $urandom_range(0, 1)));

    // Broader random traffic with shifting read/write bias.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 50) % 2 == 0 ? 70 : 30;
      step("rand", 1'($urandom_range(0, 99) < bias), 8'($urandom),
           1'($urandom_range(0, 99) < 100 - bias));
    end

    // Asynchronous reset between edges with five entries held.
    while (q.size() > 0) step("flush", 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h30 + i), 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b1);
    step("pre_rst_wr", 1'b1, 8'h3F, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_wr", 1'b1, 8'h77, 1'b0);
    step("post_rd", 1'b0, '0, 1'b1);
    chk("post_rd.dout", 32'(data_out), 32'h77);

`ifdef SYNC_FIFO_PEAK_EN
    for (int i = 0; i < 6; i++) step("pk_fill", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step("pk_drain", 1'b0, '0, 1'b1);
    step("pk_idle", 1'b0, '0, 1'b0);
    chk("pk.max", 32'(peak_cnt), 32'd6);
    step("pk_clr", 1'b0, '0, 1'b0, 1'b1);
    chk("pk.clr", 32'(peak_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO: next-generation buffer for byte/word streams between producer and consumer in one clock domain.
- Generalises width and depth.
- Adds programmable almost-full/almost-empty thresholds.
- Adds registered read-valid, overflow/underflow error pulses and a correct simultaneous read/write policy at both boundaries.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserted when fifo_cnt >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when fifo_cnt <= AE_THRESH (0..DEPTH-1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
wr  input  1  write request
data_in  input  WIDTH  write data, sampled on accepted write
rd  input  1  read request
data_out  output  WIDTH  registered read data
rd_valid  output  1  data_out updated this cycle (pulse)
empty  output  1  fifo_cnt == 0
full  output  1  fifo_cnt == DEPTH
almost_empty  output  1  fifo_cnt <= AE_THRESH
almost_full  output  1  fifo_cnt >= AF_THRESH
fifo_cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write request rejected
underflow  output  1  one-cycle pulse: read request rejected

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- While rst is high: wr_ptr, rd_ptr = 0; fifo_cnt = 0; data_out = 0; rd_valid, overflow, underflow = 0. Memory contents are not reset.
- ADDR_W = $clog2(DEPTH). Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. fifo_cnt is ADDR_W+1 bits.
- Read accepted (rd_acc) = rd && !empty.
- Write accepted (wr_acc) = wr && (!full || rd_acc).
  - Full with rd and wr in the same cycle: both are accepted; the read returns the oldest entry and the write lands in the freed slot.
  - Empty with rd and wr in the same cycle: write accepted, read rejected. There is no fall-through.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr += 1.
- On rd_acc: data_out <= mem[rd_ptr]; rd_ptr += 1; rd_valid = 1 in the next cycle.
- Read latency is 1 cycle. data_out holds its last value when no read is accepted. rd_valid is 0 otherwise.
- fifo_cnt next value:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither occur
  - never exceeds DEPTH and never goes below 0, by construction.
- overflow <= wr && !wr_acc. underflow <= rd && !rd_acc. Both are registered one-cycle pulses. FIFO state is unchanged by a rejected request.
- empty, full, almost_empty and almost_full are combinational decodes of fifo_cnt only. They have no glitch paths from wr/rd.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Data in flight is discarded. The first accepted write after release goes to mem[0].

Optional Feature:
Macro SYNC_FIFO_PEAK_EN.
- Defined: adds output peak_cnt (same width as fifo_cnt) and input peak_clr (1 bit).
  - peak_cnt holds the maximum fifo_cnt value reached since reset or since the last peak_clr.
  - peak_clr is synchronous and has priority: on peak_clr, peak_cnt <= current fifo_cnt.
  - peak_cnt resets to 0.
- Not defined: neither port exists and there is no watermark logic.

Decomposition:
Package sync_fifo_pkg holds:
- function for ADDR_W/CNT_W derivation (clog2 wrapper)
- localparam defaults for WIDTH/DEPTH
- typedef for flag bundle {empty, full, almost_empty, almost_full}

One sub-module, sync_fifo_mem: a WIDTH x DEPTH dual-port register array with one write port and a registered read port. Pointer, count and flag logic stay in the top module.

Test Plan:
- WIDTH=8, DEPTH=8: reset, then write 0x01..0x08 -> full=1 after the 8th write, fifo_cnt=8, almost_full=1 from cnt=6; 9th write -> overflow pulse, cnt stays 8.
- Read 8 times -> data_out 0x01..0x08 in order, each one cycle after rd with rd_valid; then a 9th rd -> underflow pulse, empty=1, data_out holds 0x08.
- Full, then rd and wr with data_in=0xAA in the same cycle -> cnt stays 8, no overflow, data_out=0x01; after draining, 0xAA is the last word out.
- Empty, then rd and wr with 0x55 in the same cycle -> underflow pulse, cnt=1, rd_valid=0; the next rd returns 0x55.
- Pointer wrap: 20 cycles of interleaved write/read at cnt around 3 -> output order matches a scoreboard; flags consistent with cnt every cycle.
- Reset asserted asynchronously between clock edges with cnt=5 -> outputs zero immediately; after release, write 0x77 and read it back -> data_out=0x77.
- With SYNC_FIFO_PEAK_EN defined: fill to 6, drain to 2 -> peak_cnt=6; pulse peak_clr -> peak_cnt=2.
